// File: rtl/pu_or1k_simple_dpram_be_sclk.sv
// Single-clock simple dual-port RAM with byte-lane writes, a byte-merged collision bypass,
// an optional output register and an optional post-reset clear sequencer.
//
// state    | meaning
// ST_CLEAR | sequencer zeroing mem[clr_addr] each cycle; user ports ignored
// ST_READY | normal read/write operation
module pu_or1k_simple_dpram_be_sclk #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int ENABLE_BYPASS  = 1,
    parameter int OUTPUT_REG     = 0,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            raddr,
    input  logic                             re,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
    input  logic [DATA_WIDTH-1:0]            din,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             rvalid,
    output logic                             busy
);

    localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic                    clr_last;
    logic                    re_acc;
    logic                    we_acc;
    logic                    collide;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   s1_data;
    logic [DATA_WIDTH-1:0]   byp_data;
    logic [NBYTES-1:0]       byp_mask;
    logic [DATA_WIDTH-1:0]   s1_merged;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
        end else begin
            state <= state_nxt;
        end
    end

    assign clr_last = (clr_addr == {ADDR_WIDTH{1'b1}});

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_last) state_nxt = ST_READY;
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_READY;
        endcase
        if (CLEAR_ON_RESET == 0) state_nxt = ST_READY;
    end

    always_comb begin
        busy = (state == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_addr <= '0;
        end else if (busy) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end

    // Gating with busy (rather than testing re/we first) keeps X on re/we harmless while clearing.
    assign re_acc  = re & ~busy;
    assign we_acc  = we & ~busy;
    assign collide = re_acc & we_acc & (raddr == waddr);

    always_ff @(posedge clk) begin
        if (busy) begin
            if (rst_n) mem[clr_addr] <= '0;
        end else if (we_acc) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wbe[i]) mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Stage 1 captures the pre-write word; same-cycle write lanes are merged in afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            byp_data <= '0;
            byp_mask <= '0;
        end else begin
            s1_valid <= re_acc;
            if (re_acc) begin
                s1_data  <= mem[raddr];
                byp_data <= din;
                byp_mask <= (ENABLE_BYPASS != 0 && collide) ? wbe : '0;
            end
        end
    end

    always_comb begin
        s1_merged = s1_data;
        for (int i = 0; i < NBYTES; i++) begin
            if (byp_mask[i]) s1_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = byp_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  rvalid_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout_q   <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= s1_valid;
                    if (s1_valid) dout_q <= s1_merged;
                end
            end

            assign dout   = dout_q;
            assign rvalid = rvalid_q;
        end else begin : g_noreg
            // Stage 1 only loads on an accepted read, so the merged word already holds between reads.
            assign dout   = s1_merged;
            assign rvalid = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_pu_or1k_simple_dpram_be_sclk.sv
// Self-checking bench: u0 (latency 1, bypass) and u1 (latency 2, no bypass) share stimulus and
// both clear on reset; u2 has no clear sequencer and its own ports.
module tb_pu_or1k_simple_dpram_be_sclk;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        re, we;
    logic [3:0]  raddr, waddr, wbe;
    logic [31:0] din;
    logic        re2, we2;
    logic [3:0]  raddr2, waddr2, wbe2;
    logic [31:0] din2;
    logic [31:0] dout0, dout1, dout2;
    logic        rvalid0, rvalid1, rvalid2;
    logic        busy0, busy1, busy2;

    always #5 clk = ~clk;

    pu_or1k_simple_dpram_be_sclk #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
        .ENABLE_BYPASS(1), .OUTPUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .re(re), .waddr(waddr), .we(we),
        .wbe(wbe), .din(din), .dout(dout0), .rvalid(rvalid0), .busy(busy0));

    pu_or1k_simple_dpram_be_sclk #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
        .ENABLE_BYPASS(0), .OUTPUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .re(re), .waddr(waddr), .we(we),
        .wbe(wbe), .din(din), .dout(dout1), .rvalid(rvalid1), .busy(busy1));

    pu_or1k_simple_dpram_be_sclk #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
        .ENABLE_BYPASS(1), .OUTPUT_REG(0), .CLEAR_ON_RESET(0)) u2 (
        .clk(clk), .rst_n(rst_n), .raddr(raddr2), .re(re2), .waddr(waddr2), .we(we2),
        .wbe(wbe2), .din(din2), .dout(dout2), .rvalid(rvalid2), .busy(busy2));

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;

    typedef struct {
        logic        r;
        logic [3:0]  ra;
        logic        w;
        logic [3:0]  wa;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    sb_t  q0[$];
    sb_t  q1[$];
    vec_t tbl[8];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: each queued read must appear exactly on its due cycle; any other rvalid is an error.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q0.size() > 0 && q0[0].due == cyc) begin
                total++;
                if (rvalid0 !== 1'b1 || dout0 !== q0[0].data) begin
                    bad++;
                    $display("FAIL rd0: rvalid=%b dout=%h want %h", rvalid0, dout0, q0[0].data);
                end
                void'(q0.pop_front());
            end else if (rvalid0 !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL rv0: stray rvalid=%b dout=%h", rvalid0, dout0);
            end
            if (q1.size() > 0 && q1[0].due == cyc) begin
                total++;
                if (rvalid1 !== 1'b1 || dout1 !== q1[0].data) begin
                    bad++;
                    $display("FAIL rd1: rvalid=%b dout=%h want %h", rvalid1, dout1, q1[0].data);
                end
                void'(q1.pop_front());
            end else if (rvalid1 !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL rv1: stray rvalid=%b dout=%h", rvalid1, dout1);
            end
        end
    end

    task automatic op(input logic r, input logic [3:0] ra, input logic w, input logic [3:0] wa,
                      input logic [3:0] be, input logic [31:0] d,
                      input logic [31:0] e0, input logic [31:0] e1);
        @(negedge clk);
        re = r; raddr = ra; we = w; waddr = wa; wbe = be; din = d;
        if (r) begin
            q0.push_back('{data: e0, due: cyc + 1});
            q1.push_back('{data: e1, due: cyc + 2});
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 20) begin
            @(negedge clk);
            re = 1'b0; we = 1'b0;
            #1;
            n++;
        end
        total++;
        if (q0.size() > 0 || q1.size() > 0) begin
            bad++;
            $display("FAIL drain: pending q0=%0d q1=%0d want 0", q0.size(), q1.size());
        end
    endtask

    // Called at the negedge where rst_n is released; counts busy cycles, optionally poking the ports.
    task automatic clear_window(input string tag, input bit poke);
        int n0 = 0;
        int n1 = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy0) n0++;
            if (busy1) n1++;
            if (!busy0 && !busy1) break;
            if (poke) begin
                re = 1'b1; raddr = 4'd0; we = 1'b1; waddr = 4'd0; wbe = 4'hF; din = 32'hDEADBEEF;
            end
            @(negedge clk);
        end
        re = 1'b0; we = 1'b0;
        chk({tag, "_busy0"}, n0, 16);
        chk({tag, "_busy1"}, n1, 16);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; re = 1'b0; we = 1'b0; raddr = '0; waddr = '0; wbe = '0; din = '0;
        re2 = 1'b0; we2 = 1'b0; raddr2 = '0; waddr2 = '0; wbe2 = '0; din2 = '0;

        tbl[0] = '{1'b0, 4'd0, 1'b1, 4'd3, 4'hF,    32'hAABBCCDD, 32'h0,        32'h0};
        tbl[1] = '{1'b0, 4'd0, 1'b1, 4'd3, 4'b0101, 32'h11223344, 32'h0,        32'h0};
        tbl[2] = '{1'b1, 4'd3, 1'b0, 4'd0, 4'h0,    32'h0,        32'hAA22CC44, 32'hAA22CC44};
        tbl[3] = '{1'b0, 4'd0, 1'b1, 4'd5, 4'hF,    32'h12345678, 32'h0,        32'h0};
        tbl[4] = '{1'b1, 4'd5, 1'b1, 4'd5, 4'b1100, 32'hDEADBEEF, 32'hDEAD5678, 32'h12345678};
        tbl[5] = '{1'b1, 4'd5, 1'b0, 4'd0, 4'h0,    32'h0,        32'hDEAD5678, 32'hDEAD5678};
        tbl[6] = '{1'b0, 4'd0, 1'b1, 4'd2, 4'hF,    32'h0BADF00D, 32'h0,        32'h0};
        tbl[7] = '{1'b1, 4'd2, 1'b0, 4'd0, 4'h0,    32'h0,        32'h0BADF00D, 32'h0BADF00D};

        repeat (2) @(negedge clk);
        chk("rst_dout0", dout0, 32'h0);
        chk("rst_dout1", dout1, 32'h0);
        chk("rst_dout2", dout2, 32'h0);
        chk("rst_rvalid0", {31'h0, rvalid0}, 32'h0);
        chk("rst_rvalid1", {31'h0, rvalid1}, 32'h0);
        chk("rst_busy0", {31'h0, busy0}, 32'h1);
        chk("rst_busy2", {31'h0, busy2}, 32'h0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        clear_window("init", 1'b0);

        // No-clear instance: partial-write collision bypass, latency 1, then hold.
        @(negedge clk);
        we2 = 1'b1; waddr2 = 4'd7; wbe2 = 4'hF; din2 = 32'hCAFEF00D;
        @(negedge clk);
        re2 = 1'b1; raddr2 = 4'd7; we2 = 1'b1; waddr2 = 4'd7; wbe2 = 4'b0011; din2 = 32'h12345678;
        @(negedge clk);
        re2 = 1'b0; we2 = 1'b0;
        chk("u2_bypass", dout2, 32'hCAFE5678);
        chk("u2_rvalid", {31'h0, rvalid2}, 32'h1);
        @(negedge clk);
        chk("u2_rvalid_end", {31'h0, rvalid2}, 32'h0);
        chk("u2_hold", dout2, 32'hCAFE5678);
        re2 = 1'b1; raddr2 = 4'd7;
        @(negedge clk);
        re2 = 1'b0;
        chk("u2_reread", dout2, 32'hCAFE5678);
        chk("u2_busy", {31'h0, busy2}, 32'h0);

        // Fill with ones, reset, then clear must zero everything despite busy-time accesses.
        for (int i = 0; i < 16; i++) op(1'b0, 4'd0, 1'b1, 4'(i), 4'hF, 32'hFFFFFFFF, 32'h0, 32'h0);
        @(negedge clk);
        re = 1'b0; we = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_window("t1", 1'b1);
        for (int i = 0; i < 16; i++) op(1'b1, 4'(i), 1'b0, 4'd0, 4'h0, 32'h0, 32'h0, 32'h0);
        drain();

        for (int i = 0; i < 8; i++)
            op(tbl[i].r, tbl[i].ra, tbl[i].w, tbl[i].wa, tbl[i].be, tbl[i].d, tbl[i].e0, tbl[i].e1);
        repeat (6) begin
            @(negedge clk);
            re = 1'b0; we = 1'b0;
        end
        chk("hold0", dout0, 32'h0BADF00D);
        chk("hold1", dout1, 32'h0BADF00D);

        // Back-to-back streaming reads.
        for (int i = 0; i < 16; i++)
            op(1'b0, 4'd0, 1'b1, 4'(i), 4'hF, 32'(i) * 32'h01010101, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++)
            op(1'b1, 4'(i), 1'b0, 4'd0, 4'h0, 32'h0, 32'(i) * 32'h01010101, 32'(i) * 32'h01010101);
        drain();

        // Reset with a read in flight on the registered-output instance, then reset mid-clear.
        @(negedge clk);
        re = 1'b1; raddr = 4'd1;
        q0.push_back('{data: 32'h01010101, due: cyc + 1});
        @(negedge clk);
        re = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("t5_dout0", dout0, 32'h0);
        chk("t5_dout1", dout1, 32'h0);
        chk("t5_rvalid0", {31'h0, rvalid0}, 32'h0);
        chk("t5_rvalid1", {31'h0, rvalid1}, 32'h0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_busy_mid", {31'h0, busy1}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_window("t5", 1'b0);
        for (int i = 0; i < 16; i++) op(1'b1, 4'(i), 1'b0, 4'd0, 4'h0, 32'h0, 32'h0, 32'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pu_or1k_simple_dpram_be_sclk.md
Name: pu_or1k_simple_dpram_be_sclk

Overview:
Single-clock simple dual-port RAM with one read port and one write port, generalised from the basic dpram.
- Adds per-byte write enables and a byte-merged read-during-write bypass.
- Adds an optional output pipeline register with a read-valid strobe.
- Adds an optional hardware clear sequencer that runs after reset.
- Used for cache data/tag arrays and register-file style storage where partial-word stores must be visible to a colliding read.

Parameters:
- ADDR_WIDTH, 10, address bits; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NBYTES = DATA_WIDTH/BYTE_WIDTH.
- ENABLE_BYPASS, 1, when 1 a same-cycle read/write collision returns byte-merged new data.
- OUTPUT_REG, 0, when 1 adds an output register stage, making read latency 2.
- CLEAR_ON_RESET, 0, when 1 zeroes every word after reset release via a sequencer.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- raddr  in  ADDR_WIDTH  read address.
- re  in  1  read enable.
- waddr  in  ADDR_WIDTH  write address.
- we  in  1  write enable.
- wbe  in  NBYTES  byte-lane write enables; lane i = din[i*BYTE_WIDTH +: BYTE_WIDTH].
- din  in  DATA_WIDTH  write data.
- dout  out  DATA_WIDTH  read data.
- rvalid  out  1  one-cycle pulse when dout carries the result of an accepted read.
- busy  out  1  clear sequencer active; re/we ignored.

Behaviour:
Reset
- Reset is synchronous and active-low: rst_n low at a posedge resets.
- On reset: dout=0, rvalid=0, all pipeline valids and bypass state = 0.
- FSM goes to CLEAR (clear address counter = 0) if CLEAR_ON_RESET=1, else READY.
- Memory contents are not altered by reset itself.

FSM (CLEAR, READY)
- busy = (state==CLEAR).
- In CLEAR, each cycle with rst_n high writes 0 to mem[clr_addr] and increments clr_addr.
- After writing address 2^ADDR_WIDTH-1, go to READY on the next edge. busy is therefore high for exactly 2^ADDR_WIDTH cycles after reset release.
- Reset asserted mid-clear restarts the clear from address 0.
- CLEAR_ON_RESET=0: FSM is constant READY and busy=0.

Accepted operations
- An operation is accepted only when it is enabled (re or we) and busy=0.

Write
- Accepted we: for every lane with wbe[i]=1, mem[waddr] lane i <= din lane i; other lanes are unchanged.
- we with wbe=0 is a no-op.

Read
- Accepted re: stage 1 captures mem[raddr] as the array value before any same-cycle write.
- OUTPUT_REG=0: dout = stage 1 result, rvalid one cycle after re (latency 1).
- OUTPUT_REG=1: stage 1 → output register, latency 2; rvalid pulses 2 cycles after re.
- Fully pipelined: one read accepted per cycle, results returned in order.

Hold
- With no accepted read, dout holds its last value and rvalid=0.

Collision (accepted re and we, raddr==waddr, same cycle)
- ENABLE_BYPASS=1: result lane i = din lane i if wbe[i], else old mem lane. Implemented by registering din and wbe-mask at the read and merging at stage 1.
- ENABLE_BYPASS=0: result = old word in all lanes.
- A write in any later cycle never modifies an already-launched read. Rule: a read observes all writes accepted in earlier cycles, plus same-cycle lanes when bypass is on.
- An accepted re without collision clears the bypass mask.

Width and address
- Address wraps naturally (no range checking).
- X on re/we while busy has no effect.

Test Plan:
All tests use ADDR_WIDTH=4, DATA_WIDTH=32, BYTE_WIDTH=8.
1. CLEAR_ON_RESET=1, memory pre-filled with 0xFFFFFFFF, rst_n low 2 cycles then high → busy=1 for exactly 16 cycles. Then reading addresses 0..15 returns 0x00000000 each, with one rvalid pulse per read.
2. OUTPUT_REG=0: write 0xAABBCCDD to addr 3 (wbe=4'hF), then write din=0x11223344, wbe=4'b0101 to addr 3, then re addr 3 → dout=0xAA22CC44 with rvalid exactly 1 cycle after re. Repeat with OUTPUT_REG=1 → same value at 2 cycles.
3. mem[5]=0x12345678; same cycle re/we addr 5, wbe=4'b1100, din=0xDEADBEEF → dout=0xDEAD5678 (ENABLE_BYPASS=1) or 0x12345678 (ENABLE_BYPASS=0). A following read of addr 5 returns 0xDEAD5678 in both cases.
4. Single re of addr 2 (=0x0BADF00D), then 6 idle cycles; also re/we asserted while busy=1 → dout stays 0x0BADF00D, rvalid is a single pulse, and busy-time accesses produce no rvalid and no memory change.
5. CLEAR_ON_RESET=1, OUTPUT_REG=1: assert rst_n low at the 7th clear cycle with a read in flight → next edge dout=0, rvalid=0. After release busy=1 for a full 16 cycles, and addresses 0..15 all read 0.
6. OUTPUT_REG=1: mem[i]=i*0x01010101; re every cycle for addresses 0..15 → rvalid high 16 consecutive cycles starting 2 cycles after the first re, with dout=0x00000000, 0x01010101, …, 0x0F0F0F0F in order.
